// File: rtl/instr_encoder.sv
// RV32I R/I-type instruction encoder feeding a word FIFO with auto-incrementing address.
// Define ENCODER_CHECK_EN to drop illegal descriptors and pulse err_o on their accept.
module instr_encoder #(
  parameter int                DEPTH       = 4,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ALU_CONTROL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     op_valid_i,
  output logic                     op_ready_o,
  input  logic [ALU_CONTROL-1:0]   alu_ctrl_i,
  input  logic                     is_imm_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [11:0]              imm_i,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  output logic [31:0]              instr_data_o,
  output logic [ADDR_W-1:0]        instr_addr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]       w_f3;
  logic             w_alt;
  logic             w_shift;
  logic             w_legal;
  logic [11:0]      w_imm;
  logic [31:0]      w_word;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic [ADDR_W-1:0] r_addr;

  always_comb begin
    w_f3    = 3'b000;
    w_alt   = 1'b0;
    w_shift = 1'b0;
    w_legal = 1'b1;
    unique case (alu_ctrl_i)
      ALU_CONTROL'(0): w_f3 = 3'b000;
      ALU_CONTROL'(1): begin
        w_f3  = 3'b000;
        w_alt = 1'b1;
      end
      ALU_CONTROL'(2): begin
        w_f3    = 3'b001;
        w_shift = 1'b1;
      end
      ALU_CONTROL'(3): w_f3 = 3'b010;
      ALU_CONTROL'(4): w_f3 = 3'b011;
      ALU_CONTROL'(5): w_f3 = 3'b100;
      ALU_CONTROL'(6): begin
        w_f3    = 3'b101;
        w_shift = 1'b1;
      end
      ALU_CONTROL'(7): begin
        w_f3    = 3'b101;
        w_alt   = 1'b1;
        w_shift = 1'b1;
      end
      ALU_CONTROL'(8): w_f3 = 3'b110;
      ALU_CONTROL'(9): w_f3 = 3'b111;
      default:         w_legal = 1'b0;
    endcase
    // No SUBI in RV32I
    if (is_imm_i && alu_ctrl_i == ALU_CONTROL'(1)) w_legal = 1'b0;
    if (!w_legal) begin
      w_f3    = 3'b000;
      w_alt   = 1'b0;
      w_shift = 1'b0;
    end
  end

  always_comb begin
    w_imm = imm_i;
    if (w_shift) w_imm = {w_alt ? 7'b0100000 : 7'b0, imm_i[4:0]};
  end

  assign w_word = is_imm_i
    ? {w_imm, rs1_i, w_f3, rd_i, 7'b0010011}
    : {w_alt ? 7'b0100000 : 7'b0, rs2_i, rs1_i, w_f3, rd_i, 7'b0110011};

  assign op_ready_o    = (r_count < CNT_W'(DEPTH)) & ~clear_i;
  assign w_accept      = op_valid_i & op_ready_o;
  assign instr_valid_o = (r_count != '0);
  assign w_pop         = instr_valid_o & instr_ready_i;

`ifdef ENCODER_CHECK_EN
  assign w_drop = ~w_legal;
  assign err_o  = w_accept & ~w_legal;
`else
  assign w_drop = 1'b0;
  assign err_o  = 1'b0;
`endif

  assign w_push = w_accept & ~w_drop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
    end else if (clear_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_addr <= r_addr + ADDR_W'(4);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign instr_data_o = instr_valid_o ? r_mem[r_rd] : 32'h0;
  assign instr_addr_o = r_addr;
  assign count_o      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboarded random/directed bench for instr_encoder (small address space to exercise wrap).
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam logic [AW-1:0] BASE = 4'hC;
`ifdef ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_i;
  logic          op_valid_i;
  logic          op_ready_o;
  logic [3:0]    alu_ctrl_i;
  logic          is_imm_i;
  logic [4:0]    rd_i, rs1_i, rs2_i;
  logic [11:0]   imm_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_data_o;
  logic [AW-1:0] instr_addr_o;
  logic [2:0]    count_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;
  int rmode  = 0;
  bit mon_en = 0;
  logic [31:0]   q [$];
  logic [AW-1:0] exp_addr = BASE;

  instr_encoder #(
    .DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE), .ALU_CONTROL(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .alu_ctrl_i(alu_ctrl_i), .is_imm_i(is_imm_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_data_o(instr_data_o), .instr_addr_o(instr_addr_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: assemble RV32I fields from mnemonic tables
  function automatic logic [31:0] model(input logic [3:0] c, input logic im,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [11:0] iv);
    logic [2:0] f3tab [16];
    logic [31:0] f3, f7, immf;
    bit bad;
    f3tab = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 0, 0, 0, 0, 0};
    bad  = (c > 9) || (c == 1 && im);
    f3   = bad ? 0 : 32'(f3tab[c]);
    f7   = (!bad && (c == 1 || c == 7)) ? 32'd32 : 32'd0;
    if (!im)
      return (f7 << 25) + (32'(s2) << 20) + (32'(s1) << 15)
           + (f3 << 12) + (32'(d) << 7) + 32'd51;
    immf = 32'(iv);
    if (!bad && (c == 2 || c == 6 || c == 7))
      immf = (f7 << 5) + 32'(iv[4:0]);
    return (immf << 20) + (32'(s1) << 15) + (f3 << 12)
         + (32'(d) << 7) + 32'd19;
  endfunction

  task automatic send(input logic [3:0] c, input logic im,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [11:0] iv, input logic [31:0] w);
    bit acc = 0;
    bit bad;
    int n = 0;
    bad = (c > 9) || (c == 1 && im);
    op_valid_i = 1; alu_ctrl_i = c; is_imm_i = im;
    rd_i = d; rs1_i = s1; rs2_i = s2; imm_i = iv;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = op_ready_o;
      chk("err", {31'b0, err_o}, {31'b0, CHK && acc && bad});
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got stalled want accept");
    end else if (!(CHK && bad)) begin
      q.push_back(w);
    end
    #1 op_valid_i = 0;
  endtask

  task automatic rsend(input bit legal_only);
    logic [3:0] c;
    logic im;
    logic [4:0] d, s1, s2;
    logic [11:0] iv;
    c  = legal_only ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
    im = 1'($urandom);
    if (legal_only && c == 1) im = 0;
    d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
    iv = 12'($urandom);
    send(c, im, d, s1, s2, iv, model(c, im, d, s1, s2, iv));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear_i = 1; op_valid_i = 1;
    @(posedge clk); #1;
    clear_i = 0; op_valid_i = 0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       instr_ready_i = 0;
      1:       instr_ready_i = 1;
      default: instr_ready_i = 1'($urandom);
    endcase
  end

  // Monitor: compare outputs against the scoreboard, then retire
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en) begin
      chk("count", 32'(count_o), 32'(q.size()));
      chk("valid", {31'b0, instr_valid_o}, {31'b0, q.size() != 0});
      chk("op_ready", {31'b0, op_ready_o},
          {31'b0, (q.size() < DEPTH) && !clear_i});
      if (q.size() != 0) begin
        chk("data", instr_data_o, q[0]);
        chk("addr", 32'(instr_addr_o), 32'(exp_addr));
      end
      if (clear_i) begin
        q.delete();
        exp_addr = BASE;
      end else if (q.size() != 0 && instr_ready_i) begin
        void'(q.pop_front());
        exp_addr = exp_addr + AW'(4);
      end
    end
  end

  initial begin
    rst_n = 0; clear_i = 0; op_valid_i = 0; instr_ready_i = 0;
    alu_ctrl_i = 0; is_imm_i = 0; rd_i = 0; rs1_i = 0; rs2_i = 0;
    imm_i = 0;
    #12;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", {31'b0, instr_valid_o}, 0);
    chk("rst_data", instr_data_o, 0);
    chk("rst_addr", 32'(instr_addr_o), 32'(BASE));
    chk("rst_err", {31'b0, err_o}, 0);
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1;
    #1 chk("rst_ready", {31'b0, op_ready_o}, 1);

    rmode = 1;
    @(posedge clk); #1;
    send(4'd0, 0, 5'd3, 5'd1, 5'd2, 12'd0, 32'h002081B3);
    send(4'd1, 0, 5'd5, 5'd6, 5'd7, 12'd0, 32'h407302B3);
    send(4'd7, 1, 5'd1, 5'd2, 5'd0, 12'd3, 32'h40315093);
    drain();

    rmode = 0;
    send(4'd0, 1, 5'd1, 5'd0, 5'd0, 12'hFFF, 32'hFFF00093);
    repeat (3) @(posedge clk);
    #1 rmode = 1;
    drain();

    rmode = 0;
    @(posedge clk); #1;
    repeat (DEPTH) rsend(1);
    @(negedge clk);
    chk("full_ready", {31'b0, op_ready_o}, 0);
    chk("full_count", 32'(count_o), DEPTH);
    @(posedge clk); #1;
    rmode = 1;
    rsend(1);
    drain();

    rmode = 0;
    @(posedge clk); #1;
    repeat (3) rsend(1);
    pulse_clear();
    @(negedge clk);
    chk("clr_addr", 32'(instr_addr_o), 32'(BASE));
    chk("clr_count", 32'(count_o), 0);
    @(posedge clk); #1;
    rmode = 1;

    send(4'd10, 0, 5'd1, 5'd2, 5'd3, 12'd0, 32'h003100B3);
    send(4'd1, 1, 5'd2, 5'd3, 5'd0, 12'd5, 32'h00518113);
    drain();

    rmode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) pulse_clear();
      rsend(0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rmode = 1;
    drain();

    rmode = 0;
    repeat (3) rsend(1);
    mon_en = 0;
    rst_n  = 0;
    #2;
    chk("mid_rst_count", 32'(count_o), 0);
    chk("mid_rst_valid", {31'b0, instr_valid_o}, 0);
    chk("mid_rst_addr", 32'(instr_addr_o), 32'(BASE));
    q.delete();
    exp_addr = BASE;
    @(posedge clk); #1;
    rst_n = 1; mon_en = 1; rmode = 1;
    send(4'd5, 0, 5'd9, 5'd8, 5'd7, 12'd0, model(4'd5, 0, 5'd9, 5'd8, 5'd7, 12'd0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
